// File: rtl/img_mem_pkg.sv
// Shared types and helpers for the banked image memory.
// Bank decode is a compare chain against constant bank bases; no divider.
package img_mem_pkg;

    localparam int IMG_DEFAULT_DEPTH = 32'd40000;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } clear_state_t;

    // Returns the bank holding addr, or nb when addr lies past the last bank.
    function automatic logic [3:0] bank_of(input logic [31:0] addr, input int depth, input int nb);
        logic [3:0] idx;
        idx = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            if ((k <= nb) && (addr >= 32'(k * depth))) begin
                idx = 4'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/img_bank_ram.sv
// Single-port synchronous RAM bank with a one-cycle registered read.
// Contents are never reset; a write cycle leaves the read register untouched.
module img_bank_ram
    import img_mem_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BANK_DEPTH = IMG_DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic                   we,
    input  logic [((BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1)-1:0] addr,
    input  logic [DATA_W-1:0]      wd,
    output logic [DATA_W-1:0]      rd
);

    logic [DATA_W-1:0] mem_r [BANK_DEPTH];

    // Storage array with write-or-read per enabled cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[addr] <= wd;
            end else begin
                rd <= mem_r[addr];
            end
        end
    end

endmodule

// File: rtl/image_bank_controller.sv
// Banked image memory: flat address split over NUM_BANKS RAMs, registered read path,
// out-of-range strobe and an optional clear engine enabled by the IMGMEM_CLEAR_EN macro.
module image_bank_controller
    import img_mem_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                BANK_DEPTH  = IMG_DEFAULT_DEPTH,
    parameter int                NUM_BANKS   = 4,
    parameter int                ADDR_W      = 18,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] wd,
    input  logic              clear,
    output logic [DATA_W-1:0] rd,
    output logic              rvalid,
    output logic              err,
    output logic              busy
);

    localparam int LA_W   = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [3:0]        bank_idx_s;
    logic              in_range_s;
    logic [ADDR_W-1:0] base_s;
    logic [LA_W-1:0]   local_s;
    logic              busy_s;
    logic              start_s;
    logic              accept_s;
    logic [LA_W-1:0]   clear_addr_s;

    logic [NUM_BANKS-1:0] bank_en_s;
    logic                 bank_we_s;
    logic [LA_W-1:0]      bank_addr_s;
    logic [DATA_W-1:0]    bank_wd_s;
    logic [DATA_W-1:0]    bank_rd_s [NUM_BANKS];

    logic [BANK_W-1:0] rsel_r;
    logic              rvalid_r;
    logic              err_r;

    // Flat address decode into bank index and bank-local address.
    always_comb begin
        bank_idx_s = bank_of(32'(a), BANK_DEPTH, NUM_BANKS);
        in_range_s = (bank_idx_s < 4'(NUM_BANKS));
        base_s     = {ADDR_W{1'b0}};
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (bank_idx_s == 4'(k)) begin
                base_s = ADDR_W'(k * BANK_DEPTH);
            end else begin
                base_s = base_s;
            end
        end
        local_s = LA_W'(a - base_s);
    end

`ifdef IMGMEM_CLEAR_EN
    clear_state_t    state_r;
    clear_state_t    state_nxt_s;
    logic [LA_W-1:0] cnt_r;
    logic [LA_W-1:0] cnt_nxt_s;

    // Clear engine state and fill counter; reset starts a fresh pass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_CLEAR;
            cnt_r   <= {LA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Clear engine next state; a clear pulse while filling is ignored.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        start_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                cnt_nxt_s = {LA_W{1'b0}};
                if (clear) begin
                    state_nxt_s = S_CLEAR;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (cnt_r == LA_W'(BANK_DEPTH - 1)) begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = {LA_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + LA_W'(1);
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = {LA_W{1'b0}};
            end
        endcase
    end

    assign busy_s       = (state_r == S_CLEAR);
    assign clear_addr_s = cnt_r;
`else
    logic clear_unused_s;

    assign clear_unused_s = clear;
    assign busy_s         = 1'b0;
    assign start_s        = 1'b0;
    assign clear_addr_s   = {LA_W{1'b0}};
`endif

    // A clear start takes priority over a same-cycle access.
    assign accept_s = req & ~busy_s & ~start_s;

    // Bank port steering: clear pass writes every bank in parallel.
    always_comb begin
        bank_we_s   = busy_s ? 1'b1 : we;
        bank_addr_s = busy_s ? clear_addr_s : local_s;
        bank_wd_s   = busy_s ? CLEAR_VALUE : wd;
        bank_en_s   = {NUM_BANKS{1'b0}};
        for (int k = 0; k < NUM_BANKS; k++) begin
            bank_en_s[k] = busy_s | (accept_s & in_range_s & (bank_idx_s == 4'(k)));
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        img_bank_ram #(
            .DATA_W    (DATA_W),
            .BANK_DEPTH(BANK_DEPTH)
        ) u_ram (
            .clk (clk),
            .en  (bank_en_s[g]),
            .we  (bank_we_s),
            .addr(bank_addr_s),
            .wd  (bank_wd_s),
            .rd  (bank_rd_s[g])
        );
    end

    // Read strobe, range error and bank select, aligned with the bank read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            rsel_r   <= {BANK_W{1'b0}};
        end else begin
            rvalid_r <= accept_s & ~we;
            err_r    <= accept_s & ~in_range_s;
            if (accept_s & in_range_s & ~we) begin
                rsel_r <= BANK_W'(bank_idx_s);
            end else begin
                rsel_r <= rsel_r;
            end
        end
    end

    // Out-of-range reads and idle cycles present zero.
    assign rd     = (rvalid_r & ~err_r) ? bank_rd_s[rsel_r] : {DATA_W{1'b0}};
    assign rvalid = rvalid_r;
    assign err    = err_r;
    assign busy   = busy_s;

endmodule

// File: tb/tb_image_bank_controller.sv
// Self-checking bench for image_bank_controller: directed table, boundary burst,
// random traffic against an address-map model, and clear/reset sequences.
module tb_image_bank_controller;

`ifdef IMGMEM_CLEAR_EN
    localparam int D        = 16;
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam int D        = 40000;
    localparam bit CLEAR_EN = 1'b0;
`endif
    localparam int          NB = 4;
    localparam int          T  = NB * D;
    localparam logic [7:0]  CV = 8'hC3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [17:0] a;
    logic [7:0]  wd;
    logic        clear;
    logic [7:0]  rd;
    logic        rvalid;
    logic        err;
    logic        busy;

    always #5 clk = ~clk;

    image_bank_controller #(
        .DATA_W     (8),
        .BANK_DEPTH (D),
        .NUM_BANKS  (NB),
        .ADDR_W     (18),
        .CLEAR_VALUE(CV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .clear (clear),
        .rd    (rd),
        .rvalid(rvalid),
        .err   (err),
        .busy  (busy)
    );

    // Reference: sparse flat memory, "everything cleared" flag, remaining clear cycles.
    logic [7:0] mem_m [int];
    bit         cleared_m = 1'b0;
    int         clear_left_m = 0;
    int         nvec = 0;
    int         nmis = 0;
    bit         e_rv, e_err, e_known;
    logic [7:0] e_rd;

    typedef struct {
        logic        r;
        logic        w;
        logic [17:0] addr;
        logic [7:0]  d;
        logic        x_rv;
        logic        x_err;
        logic [7:0]  x_rd;
        string       name;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [17:0] addr,
                         input logic [7:0] d, input logic c);
        bit acc;
        req = r; we = w; a = addr; wd = d; clear = c;
        acc     = r && (clear_left_m == 0) && !(c && CLEAR_EN);
        e_rv    = acc && !w;
        e_err   = acc && (addr >= T);
        e_known = 1'b1;
        e_rd    = 8'h00;
        if (addr < T) begin
            if (mem_m.exists(int'(addr))) e_rd = mem_m[int'(addr)];
            else if (cleared_m)           e_rd = CV;
            else                          e_known = 1'b0;
        end
        if (acc && w && (addr < T)) mem_m[int'(addr)] = d;
        @(posedge clk); #1;
        if (clear_left_m > 0) begin
            clear_left_m--;
        end else if (c && CLEAR_EN) begin
            clear_left_m = D;
            mem_m.delete();
            cleared_m = 1'b1;
        end
        check("busy", busy, clear_left_m > 0);
    endtask

    task automatic check_model(input string tag);
        check({tag, " rvalid"}, rvalid, e_rv);
        check({tag, " err"}, err, e_err);
        if (e_rv && e_known) check({tag, " rd"}, rd, e_rd);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 1'b0; we = 1'b0; clear = 1'b0; a = 18'd0; wd = 8'h00;
        repeat (2) begin
            @(posedge clk); #1;
            check("reset rvalid", rvalid, 1'b0);
            check("reset err", err, 1'b0);
            check("reset rd", rd, 8'h00);
            check("reset busy", busy, CLEAR_EN);
        end
        rst_n = 1'b1;
        if (CLEAR_EN) begin
            mem_m.delete();
            cleared_m    = 1'b1;
            clear_left_m = D;
        end else begin
            clear_left_m = 0;
        end
    endtask

    // Counts busy cycles while hammering reads that must all be dropped.
    task automatic wait_clear(input int exp_n);
        int n = 0;
        while ((busy === 1'b1) && (n < D + 4)) begin
            drive(1'b1, 1'b0, 18'd3, 8'h00, 1'b0);
            check_model("busy req");
            n++;
        end
        check("busy cycles", n, exp_n);
    endtask

    initial begin
        #(2000000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        wait_clear(CLEAR_EN ? D : 0);

`ifdef IMGMEM_CLEAR_EN
        for (int i = 0; i < T; i++) begin
            drive(1'b1, 1'b0, 18'(i), 8'h00, 1'b0);
            check_model("sweep");
        end
`endif

        tbl.push_back('{1'b1, 1'b1, 18'(D - 1),     8'hA5, 1'b0, 1'b0, 8'h00, "wr_b0_last"});
        tbl.push_back('{1'b1, 1'b1, 18'(D),         8'h3C, 1'b0, 1'b0, 8'h00, "wr_b1_first"});
        tbl.push_back('{1'b1, 1'b0, 18'(D - 1),     8'h00, 1'b1, 1'b0, 8'hA5, "rd_b0_last"});
        tbl.push_back('{1'b1, 1'b0, 18'(D),         8'h00, 1'b1, 1'b0, 8'h3C, "rd_b1_first"});
        tbl.push_back('{1'b1, 1'b1, 18'(T - 1),     8'h77, 1'b0, 1'b0, 8'h00, "wr_top"});
        tbl.push_back('{1'b1, 1'b0, 18'(T - 1),     8'h00, 1'b1, 1'b0, 8'h77, "rd_top"});
        tbl.push_back('{1'b1, 1'b0, 18'(T),         8'h00, 1'b1, 1'b1, 8'h00, "rd_oor"});
        tbl.push_back('{1'b1, 1'b1, 18'd200000,     8'hEE, 1'b0, 1'b1, 8'h00, "wr_oor"});
        tbl.push_back('{1'b1, 1'b1, 18'd0,          8'h11, 1'b0, 1'b0, 8'h00, "wr_zero"});
        tbl.push_back('{1'b1, 1'b0, 18'd0,          8'h00, 1'b1, 1'b0, 8'h11, "rd_zero"});
        tbl.push_back('{1'b1, 1'b1, 18'(2 * D),     8'h5A, 1'b0, 1'b0, 8'h00, "wr_b2_first"});
        tbl.push_back('{1'b1, 1'b0, 18'(2 * D),     8'h00, 1'b1, 1'b0, 8'h5A, "rd_b2_first"});
        tbl.push_back('{1'b0, 1'b1, 18'(D - 1),     8'hFF, 1'b0, 1'b0, 8'h00, "idle_we"});
        tbl.push_back('{1'b1, 1'b0, 18'(D - 1),     8'h00, 1'b1, 1'b0, 8'hA5, "rd_after_idle"});
        tbl.push_back('{1'b1, 1'b1, 18'(3 * D + 1), 8'h4E, 1'b0, 1'b0, 8'h00, "wr_b3"});
        tbl.push_back('{1'b1, 1'b0, 18'(3 * D + 1), 8'h00, 1'b1, 1'b0, 8'h4E, "raw_b3"});
        tbl.push_back('{1'b1, 1'b0, 18'(D),         8'h00, 1'b1, 1'b0, 8'h3C, "rd_b1_again"});

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].w, tbl[i].addr, tbl[i].d, 1'b0);
            check({tbl[i].name, " rvalid"}, rvalid, tbl[i].x_rv);
            check({tbl[i].name, " err"}, err, tbl[i].x_err);
            if (tbl[i].x_rv) check({tbl[i].name, " rd"}, rd, tbl[i].x_rd);
        end

        // Burst across the bank1/bank2 boundary.
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 18'(2 * D - 10 + i), 8'(i * 7 + 1), 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 18'(2 * D - 10 + i), 8'h00, 1'b0);
            check_model("burst");
        end

        for (int i = 0; i < 400; i++) begin
            int          addr_i;
            logic        r, w;
            case ($urandom_range(0, 3))
                0:       addr_i = $urandom_range(1, 4) * D + $urandom_range(0, 5) - 3;
                1:       addr_i = $urandom_range(0, T - 1);
                2:       addr_i = T + $urandom_range(0, 1000);
                default: addr_i = $urandom_range(0, 7);
            endcase
            r = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            drive(r, w, 18'(addr_i), 8'($urandom), 1'b0);
            check_model("rand");
        end

        // Clear pulse coinciding with a write; data at a=9 shows retention or clearing.
        drive(1'b1, 1'b1, 18'd5, 8'h99, 1'b0);
        drive(1'b1, 1'b1, 18'd9, 8'h66, 1'b0);
        drive(1'b1, 1'b1, 18'd5, 8'hEE, 1'b1);
        check("clear+wr rvalid", rvalid, 1'b0);
        wait_clear(CLEAR_EN ? D : 0);
        drive(1'b1, 1'b0, 18'd5, 8'h00, 1'b0);
        check_model("post clear a5");
        drive(1'b1, 1'b0, 18'd9, 8'h00, 1'b0);
        check_model("post clear a9");

        // Reset at cnt=7 of a pass; the pass restarts in full.
        drive(1'b1, 1'b1, 18'd9, 8'h2D, 1'b0);
        drive(1'b0, 1'b0, 18'd0, 8'h00, 1'b1);
        repeat (7) drive(1'b0, 1'b0, 18'd0, 8'h00, 1'b0);
        do_reset();
        wait_clear(CLEAR_EN ? D : 0);
        drive(1'b1, 1'b0, 18'd9, 8'h00, 1'b0);
        check_model("post reset a9");
        drive(1'b1, 1'b0, 18'(T + 3), 8'h00, 1'b0);
        check_model("post reset oor");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/image_bank_controller.md
# image_bank_controller

Parametrised banked image memory for the uniciclo processor's image-processing path. It splits a flat pixel address space across NUM_BANKS equal single-port RAM banks and adds a registered read path with a valid strobe. It also flags out-of-range accesses and provides an optional hardware clear engine that fills every bank with a constant after reset or on request.

## Interface
- DATA_W, 8, pixel width in bits
- BANK_DEPTH, 40000, words per bank
- NUM_BANKS, 4, number of banks (1..8)
- ADDR_W, 18, flat address width; must satisfy NUM_BANKS*BANK_DEPTH <= 2**ADDR_W
- CLEAR_VALUE, 8'h00, fill word used by the clear engine
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  1  access request, sampled every cycle
- we  in  1  write enable, qualified by req
- a  in  ADDR_W  flat pixel address
- wd  in  DATA_W  write data
- clear  in  1  one-cycle pulse starting a clear pass
- rd  out  DATA_W  read data, valid only with rvalid
- rvalid  out  1  read data strobe
- err  out  1  out-of-range strobe
- busy  out  1  clear engine active; requests are dropped

## Operation
- Decode: bank k is selected when k*BANK_DEPTH <= a < (k+1)*BANK_DEPTH. Local address = a - k*BANK_DEPTH, truncated to clog2(BANK_DEPTH) bits.
- Decode uses a compare chain against the constants; no divider.
- Write (req=1, we=1, in range, busy=0): only the selected bank's write enable asserts. No rvalid.
- Read (req=1, we=0, in range, busy=0): the selected bank index is registered alongside the bank's synchronous read. rd is the registered-index mux of the bank outputs.
- Out of range (a >= NUM_BANKS*BANK_DEPTH): write dropped, no bank enabled. A read returns rd=0 with rvalid=1.
- err pulses 1 cycle for any out-of-range req, read or write, aligned with where rvalid would be.
- Access while busy=1: dropped silently. No rvalid, no err, no write.
- FSM (clear engine): S_IDLE, S_CLEAR.
  - S_IDLE -> S_CLEAR on clear=1.
  - In S_CLEAR: all banks are written in parallel at local address cnt with CLEAR_VALUE; cnt increments each cycle.
  - S_CLEAR -> S_IDLE after cnt = BANK_DEPTH-1 is written; cnt returns to 0.
  - clear asserted while in S_CLEAR is ignored (no restart).
- Simultaneous clear and req in S_IDLE: clear wins and the access is dropped.

## Timing
- Read latency 1: req at edge N -> rd/rvalid valid after edge N+1, held one cycle only.
- Back-to-back reads: one per cycle, fully pipelined.
- Read-after-write to the same address in the next cycle returns the new data.
- Write in the same cycle as a read of the same address cannot occur: single port, one access per cycle.
- Clear pass: busy rises the cycle after clear and stays high for exactly BANK_DEPTH cycles.
- Reset values: rd=0, rvalid=0, err=0, cnt=0.
  - Macro defined: state=S_CLEAR and busy=1, i.e. a clear pass starts automatically out of reset.
  - Macro undefined: busy=0.
- Reset mid-clear restarts the pass from cnt=0. Reset also clears any pending rvalid/err. RAM contents are not reset by rst_n itself.

## Configuration
- IMGMEM_CLEAR_EN defined: clear engine, FSM and counter compiled in; behaviour as above.
- IMGMEM_CLEAR_EN undefined:
  - clear input ignored, busy tied 0, no FSM or counter.
  - RAM contents after reset are undefined (initial file only).

## Structure
- Package img_mem_pkg holds:
  - typedef clear_state_t {S_IDLE, S_CLEAR}
  - function bank_of(addr) returning the bank index
  - constant IMG_DEFAULT_DEPTH = 40000
- Sub-module img_bank_ram: single-port synchronous RAM parametrised DATA_W/BANK_DEPTH, 1-cycle read. It is instantiated NUM_BANKS times via generate.

## Test plan
- Defaults, write 8'hA5 to a=39999 and 8'h3C to a=40000, then read both -> rd=A5 then 3C, each with rvalid one cycle after req; bank0/bank1 boundary correct.
- Read a=159999 after writing 8'h77 there -> rd=77. Read a=160000 -> rvalid=1, rd=0, err=1. Write a=200000 -> err=1, no bank modified.
- Burst of 16 consecutive reads a=79990..80005 -> 16 consecutive rvalid cycles with correct data across the bank1/bank2 boundary.
- With IMGMEM_CLEAR_EN, BANK_DEPTH=16: release reset -> busy high exactly 16 cycles. Every address then reads CLEAR_VALUE. A req during busy gives no rvalid.
- With IMGMEM_CLEAR_EN: pulse clear together with a write to a=5 -> write dropped, a=5 reads CLEAR_VALUE. Assert rst_n=0 at cnt=7 -> pass restarts, busy lasts a full 16 cycles after release.
- Without IMGMEM_CLEAR_EN: pulse clear -> busy stays 0, previously written data retained.
